// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers.
// A mult/div holds busy for a fixed number of cycles and then writes HI/LO
// from the latched operands. mthi/mtlo write HI or LO in a single cycle.
module e_mdu #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = MULT_LAT[3:0];
  localparam logic [3:0] DIV_CNT  = DIV_LAT[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Result datapath, fed only by the latched operands
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag;
  logic [31:0]        mag_quo, mag_rem;
  logic [31:0]        s_quo, s_rem;
  logic [31:0]        u_quo, u_rem;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;

  // Products, and signed division done on magnitudes so that
  // 0x80000000 / -1 wraps cleanly to 0x80000000 with remainder 0.
  always_comb begin
    prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    a_mag   = a_q[31] ? (-a_q) : a_q;
    b_mag   = b_q[31] ? (-b_q) : b_q;
    mag_quo = a_mag / b_mag;
    mag_rem = a_mag % b_mag;
    s_quo   = (a_q[31] ^ b_q[31]) ? (-mag_quo) : mag_quo;
    s_rem   = a_q[31] ? (-mag_rem) : mag_rem;
    u_quo   = a_q / b_q;
    u_rem   = a_q % b_q;
  end

  // Select the write-back value for the in-flight op; a zero divisor
  // suppresses the write so HI/LO keep their previous contents.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_we = 1'b1;
      end
      OP_DIV: begin
        res_hi = s_rem;
        res_lo = s_quo;
        res_we = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res_hi = u_rem;
        res_lo = u_quo;
        res_we = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  // Next-state: issue while idle, count down while busy, write back on the last count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_d     = A;
              b_d     = B;
              op_d    = op;
              cnt_d   = (op == OP_MULT || op == OP_MULTU) ? MULT_CNT : DIV_CNT;
              state_d = ST_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset wins over any issue and aborts an in-flight op
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign stall_req = busy | (start & (op >= OP_MULT) & (op <= OP_DIVU));
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO/latency,
// a monitor pops and compares each time busy falls.
module tb_e_mdu;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;

  e_mdu #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .A(A),
    .B(B),
    .busy(busy),
    .stall_req(stall_req),
    .HI(HI),
    .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;
  bit          abort_flag = 1'b0;
  int          busy_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count busy cycles, compare on the falling edge of busy
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (busy_run == 0 && sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_busy: busy rose with nothing issued at %0t", $time);
      end
      busy_run++;
    end else if (busy_run > 0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_completion: busy ran %0d cycles, none expected", busy_run);
      end else begin
        mon_e = sb.pop_front();
        if (abort_flag) begin
          abort_flag = 1'b0;
        end else begin
          chk("busy_cycles", 32'(busy_run), 32'(mon_e.lat));
          chk("result_hi", HI, mon_e.hi);
          chk("result_lo", LO, mon_e.lo);
        end
      end
      busy_run = 0;
    end
  end

  // Drive one op at a negedge, update the reference model, check one-cycle effects
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t            e;
    bit              md;
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    logic [63:0]     w;
    md = (o >= 3'd1) && (o <= 3'd4);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = a;
    ub  = b;
    case (o)
      3'd1: begin
        w = sa * sbv;
        mhi = w[63:32];
        mlo = w[31:0];
      end
      3'd2: begin
        w = ua * ub;
        mhi = w[63:32];
        mlo = w[31:0];
      end
      3'd3: begin
        if (b != 32'd0) begin
          q = sa / sbv;
          r = sa % sbv;
          w = q;
          mlo = w[31:0];
          w = r;
          mhi = w[31:0];
        end
      end
      3'd4: begin
        if (b != 32'd0) begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      3'd5: mhi = a;
      3'd6: mlo = a;
      default: ;
    endcase
    if (md) begin
      e.hi  = mhi;
      e.lo  = mlo;
      e.lat = (o <= 3'd2) ? MLAT : DLAT;
      sb.push_back(e);
    end
    #1 chk("stall_req_issue", 32'(stall_req), 32'(md));
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    chk("busy_after_issue", 32'(busy), 32'(md));
    if (!md) begin
      chk("hi_direct", HI, mhi);
      chk("lo_direct", LO, mlo);
    end
    $display("issue op=%0d A=%08h B=%08h -> model HI=%08h LO=%08h", o, a, b, mhi, mlo);
  endtask

  // Wait for busy to drop, optionally hammering inputs while busy
  task automatic wait_done(input bit noise);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
        #1 chk("stall_req_busy", 32'(stall_req), 32'd1);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    op    = 3'd0;
    if (n >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall_req), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed values
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_done(1'b0);
    chk("mult_hi_const", HI, 32'hFFFFFFFF);
    chk("mult_lo_const", LO, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    wait_done(1'b0);
    chk("multu_hi_const", HI, 32'h00000001);
    chk("multu_lo_const", LO, 32'hFFFFFFFE);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b0);
    chk("div_hi_const", HI, 32'hFFFFFFFF);
    chk("div_lo_const", LO, 32'hFFFFFFFD);
    issue(3'd4, 32'd7, 32'd0);
    wait_done(1'b0);
    chk("divu0_hi_const", HI, 32'hFFFFFFFF);
    chk("divu0_lo_const", LO, 32'hFFFFFFFD);
    issue(3'd5, 32'h12345678, 32'd0);
    chk("mthi_const", HI, 32'h12345678);
    issue(3'd6, 32'hA5A5A5A5, 32'd0);
    chk("mtlo_const", LO, 32'hA5A5A5A5);
    chk("mtlo_hi_kept", HI, 32'h12345678);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0);
    chk("ovf_hi_const", HI, 32'h00000000);
    chk("ovf_lo_const", LO, 32'h80000000);

    // Start while busy is ignored; back-to-back issue on first idle cycle
    issue(3'd1, $urandom, $urandom);
    @(negedge clk);
    start = 1'b1;
    op    = 3'd3;
    A     = $urandom;
    B     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    wait_done(1'b0);
    issue(3'd3, $urandom, 32'd9);
    wait_done(1'b0);

    // Reset at busy cycle 4 aborts the divide
    issue(3'd3, $urandom, 32'd3);
    repeat (3) @(negedge clk);
    abort_flag = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mhi = 32'd0;
    mlo = 32'd0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk("abort_quiet_hi", HI, 32'd0);
      chk("abort_quiet_lo", LO, 32'd0);
      chk("abort_quiet_busy", 32'(busy), 32'd0);
    end

    // Randomized back-to-back traffic with noise on inputs while busy
    for (int i = 0; i < 80; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 15))
        0, 1:    rb = 32'd0;
        2:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3, 4:    begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      issue(ro, ra, rb);
      if (ro >= 3'd1 && ro <= 3'd4) wait_done(1'b1);
    end

    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_LAT, default 5: cycles busy is held for mult/multu; legal range 1..15.
REQ-002 Parameter DIV_LAT, default 10: cycles busy is held for div/divu; legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  issue strobe for the operation on op; sampled on each rising edge.
REQ-006 op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 A  input  32  rs operand (multiplicand / dividend / mthi-mtlo source).
REQ-008 B  input  32  rt operand (multiplier / divisor).
REQ-009 busy  output  1  registered; high while a mult/div is in flight.
REQ-010 stall_req  output  1  combinational; equals busy OR (start AND op in 1..4); drives the E-stage stall of mfhi/mflo/md instructions.
REQ-011 HI  output  32  registered HI register, fed to the E->M pipeline register.
REQ-012 LO  output  32  registered LO register, fed to the E->M pipeline register.

Function
REQ-013 Accepted issue: start=1, busy=0 and op in 1..6 at a rising edge; start with op 0 or 7 does nothing.
REQ-014 An accepted mult/div latches A, B and op into internal registers, loads the 4-bit counter with MULT_LAT or DIV_LAT, and sets busy=1 on that edge.
REQ-015 While busy, the counter decrements by 1 every edge; on the edge where it is 1, the result is written to HI/LO and busy clears on that same edge.
REQ-016 busy is therefore high for exactly MULT_LAT or DIV_LAT cycles; the new HI/LO are visible in the first cycle with busy=0.
REQ-017 mult: signed 32x32 to 64-bit product; HI = bits 63:32, LO = bits 31:0.
REQ-018 multu: unsigned 32x32 to 64-bit product, same HI/LO split.
REQ-019 div: signed division; LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend.
REQ-020 divu: unsigned division; LO = quotient, HI = remainder.
REQ-021 Division by zero: busy runs the full DIV_LAT cycles, and HI and LO keep their prior values.
REQ-022 Signed overflow: div with 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-023 mthi and mtlo take effect in one cycle: HI or LO is set to A on the accepting edge, busy stays 0, and the other register is unchanged.
REQ-024 start while busy=1 is ignored entirely: operands, counter and HI/LO are unaffected and no error is flagged.
REQ-025 Back-to-back operation: a start accepted in the first cycle after busy falls is legal and uses the freshly written HI/LO as its baseline.
REQ-026 HI/LO change only on the completion edge (REQ-015), on an mthi/mtlo edge (REQ-023), or on reset.
REQ-027 Computation is performed on the latched operands only; changes on A, B or op while busy have no effect on the result.

Reset
REQ-028 On reset=1 at a rising edge: HI=0, LO=0, busy=0, counter=0, latched operands=0.
REQ-029 Reset has priority over start.
REQ-030 Reset during busy aborts the operation: no result is written and the block is idle in the next cycle.

Verification
REQ-031 Reset, then mult with A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu with A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-033 div with A=-7 (0xFFFFFFF9), B=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=0 -> HI/LO unchanged.
REQ-034 mthi with A=0x12345678 -> HI=0x12345678 next cycle with busy never asserted; then mtlo with A=0xA5A5A5A5 -> LO=0xA5A5A5A5 and HI unchanged.
REQ-035 Issue mult, assert start with op=div at busy cycle 2 -> start ignored and the mult result is correct; issue div on the cycle busy falls -> accepted.
REQ-036 Issue div, assert reset at busy cycle 4 -> HI=LO=0 and busy=0 next cycle, and no late write-back occurs over the following 10 cycles.
